mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between instruction fetch (stage 1) and load/store (stage 4).
- Issues one memory transaction at a time over a ready/valid handshake and routes each response back to the requester that owns it.
- Data requests have priority because they belong to the older instruction.
- A pipeline flush cancels an in-flight fetch response.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (word).
- MAX_WAIT, 4, consecutive denied fetch cycles before fetch gets forced priority (fairness feature only).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline redirect; cancels fetch traffic
- i_req  in  1  fetch request; held stable until i_grant
- i_addr  in  ADDR_W  fetch address
- i_grant  out  1  fetch request accepted by memory this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  DATA_W  fetched instruction word
- d_req  in  1  load/store request; held stable until d_grant
- d_we  in  1  1 = store
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_wmask  in  4  store byte enables
- d_grant  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid / store complete
- d_rdata  out  DATA_W  load data
- mem_req  out  1  request to memory
- mem_we, mem_addr, mem_wdata, mem_wmask  out  1/ADDR_W/DATA_W/4  forwarded from winner (fetch: we=0, mask=0)
- mem_ready  in  1  memory accepts mem_req this cycle
- mem_rvalid  in  1  response (read data or write done)
- mem_rdata  in  DATA_W  read data

Behaviour:
- States:
  - IDLE: may issue.
  - WAIT_I: fetch outstanding.
  - WAIT_D: data outstanding.
- IDLE arbitration:
  - Winner is data if d_req, else fetch if i_req and not flush.
  - mem_req is combinational: 1 when a winner exists. mem_* fields are muxed from the winner.
- Grant: x_grant = mem_req & mem_ready & (winner == x). On grant, go to WAIT_x. Without mem_ready, stay in IDLE and re-arbitrate next cycle; the winner may change.
- WAIT_x:
  - mem_req = 0; requests are ignored.
  - On mem_rvalid: x_rvalid = 1 and x_rdata = mem_rdata in the same cycle (combinational pass-through), then go to IDLE.
- Latency: response is at least 1 cycle after grant. The next issue happens no earlier than the cycle after mem_rvalid, so throughput is at most 1 transaction per 2 cycles.
- Stores also finish through mem_rvalid. d_rvalid marks completion; d_rdata is don't-care for stores.
- Flush:
  - Flush during WAIT_I, or in the cycle of the i_grant, sets a drop flag.
  - The matching response is consumed with i_rvalid held at 0; the FSM still returns to IDLE and the drop flag clears.
  - Flush never affects data transactions.
  - Flush in IDLE blocks the fetch grant for that cycle only.
- mem_rvalid while in IDLE: ignored, no output asserted. This covers a late response after reset.
- Simultaneous d_req and i_req: data wins (fairness feature aside).
- Reset: state IDLE, drop flag 0, wait counter 0.
  - All outputs 0: grants, rvalids, mem_req, mem_* fields, and rdata outputs. rdata drives 0 whenever its rvalid is 0.
  - Reset mid-transaction abandons the outstanding request silently.
- Assertions (sim only): i_grant and d_grant are never both 1; mem_req is never 1 outside IDLE.

Optional Feature:
- Macro: MEM_ARB_FAIRNESS_EN.
- Defined:
  - A saturating wait counter (width clog2(MAX_WAIT+1)) increments each IDLE cycle that i_req & !flush is high and fetch is not granted.
  - When the counter equals MAX_WAIT and both requests are present, fetch wins.
  - The counter clears on i_grant, on flush, and on reset.
- Undefined: strict data priority; the counter is not synthesized; MAX_WAIT is unused.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, mem_ready=1, mem_rvalid 2 cycles later with mem_rdata=0x00500093 -> i_grant for 1 cycle, mem_addr=0x100, mem_we=0, then i_rvalid=1 with i_rdata=0x00500093; FSM back to IDLE.
- Contention: i_req and d_req both high, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wmask=0xF -> d_grant first with mem_we=1 and mem fields matching; after d_rvalid, i_grant in the following IDLE cycle.
- Backpressure: d_req high with mem_ready=0 for 3 cycles -> mem_req held high, no grant; grant in the cycle mem_ready rises.
- Flush drop: fetch granted, flush=1 the next cycle, mem_rvalid=1 two cycles later -> i_rvalid stays 0, FSM returns to IDLE, and a new fetch is grantable the cycle after.
- Reset mid-transaction: reset asserted while in WAIT_D, then mem_rvalid arrives after reset -> d_rvalid=0, all outputs 0, state IDLE.
- Fairness (macro defined, MAX_WAIT=4): d_req and i_req held continuously, each data transaction taking 2 cycles -> fetch granted once the counter reaches 4, ahead of a pending d_req. With the macro undefined, fetch is never granted while d_req stays high.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one data-memory port between instruction fetch (i_*) and
// load/store (d_*). One transaction is outstanding at a time; the response
// is routed back to whichever requester owns it. Data requests win over
// fetch because they belong to the older instruction. A flush cancels any
// in-flight fetch response (it is consumed but never reported).
//
// Optional feature macro: MEM_ARB_FAIRNESS_EN
//   When defined, a saturating wait counter tracks consecutive IDLE cycles
//   in which a fetch was denied. Once it reaches MAX_WAIT, fetch wins over
//   a pending data request. When undefined, data priority is strict.
//
// Ports
//   clock, reset            : clock, synchronous active-high reset
//   flush                   : pipeline redirect, cancels fetch traffic
//   i_req/i_addr            : fetch request (held until i_grant)
//   i_grant/i_rvalid/i_rdata: fetch accept, response valid, instruction word
//   d_req/d_we/d_addr/d_wdata/d_wmask : load/store request (held until d_grant)
//   d_grant/d_rvalid/d_rdata: data accept, completion, load data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wmask : request to memory
//   mem_ready               : memory accepts mem_req this cycle
//   mem_rvalid/mem_rdata    : memory response
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_grant,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wmask,
    output logic              d_grant,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   drop, drop_nxt;     // outstanding fetch response must be discarded

    logic issue_ok;
    logic win_i, win_d;
    logic fetch_force;
    logic resp_ok;

    // MAX_WAIT must allow at least one denied cycle before forcing fetch.
    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("mem_port_arbiter: MAX_WAIT must be >= 1");
    end

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;

    assign fetch_force = (wait_cnt == CNT_W'(MAX_WAIT)) & i_req & d_req & ~flush;
`else
    assign fetch_force = 1'b0;
`endif

    // Outputs are forced low while reset is held so the port is quiet even
    // before the state register has been cleared.
    assign issue_ok = (state == IDLE) & ~reset;
    assign resp_ok  = mem_rvalid & ~reset;

    // Arbitration: data first unless the fairness counter has saturated.
    // Flush only ever blocks fetch.
    assign win_d = issue_ok & d_req & ~fetch_force;
    assign win_i = issue_ok & i_req & ~flush & (~d_req | fetch_force);

    assign mem_req = win_d | win_i;
    assign d_grant = win_d & mem_ready;
    assign i_grant = win_i & mem_ready;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = 4'h0;
        if (win_d) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wmask = d_wmask;
        end else if (win_i) begin
            mem_addr  = i_addr;
        end
    end

    // Response routing is a pure pass-through. A flush arriving in the same
    // cycle as the fetch response also suppresses it: the word is stale.
    assign i_rvalid = resp_ok & (state == WAIT_I) & ~drop & ~flush;
    assign d_rvalid = resp_ok & (state == WAIT_D);
    assign i_rdata  = i_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

    always_comb begin
        state_nxt = state;
        drop_nxt  = drop;
        unique case (state)
            IDLE: begin
                drop_nxt = 1'b0;
                if (d_grant) begin
                    state_nxt = WAIT_D;
                end else if (i_grant) begin
                    state_nxt = WAIT_I;
                    drop_nxt  = flush;
                end
            end
            WAIT_I: begin
                if (mem_rvalid) begin
                    state_nxt = IDLE;
                    drop_nxt  = 1'b0;
                end else if (flush) begin
                    drop_nxt  = 1'b1;
                end
            end
            WAIT_D: begin
                if (mem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                drop_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            drop  <= 1'b0;
        end else begin
            state <= state_nxt;
            drop  <= drop_nxt;
        end
    end

`ifdef MEM_ARB_FAIRNESS_EN
    // Counts IDLE cycles where fetch was eligible but lost; saturates.
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (i_grant | flush) begin
            wait_cnt_nxt = '0;
        end else if (issue_ok & i_req & (wait_cnt != CNT_W'(MAX_WAIT))) begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
        end
    end
`endif

`ifndef SYNTHESIS
    a_one_grant : assert property (@(posedge clock) disable iff (reset)
        !(i_grant && d_grant));
    a_req_idle  : assert property (@(posedge clock) disable iff (reset)
        mem_req |-> (state == IDLE));
`endif

endmodule
